// File: rtl/game_pkg.sv
// Shared types and helpers for the keypad front end of the game controller.
package game_pkg;

  localparam int unsigned KEY_W    = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned COL_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    CANDIDATE,
    PRESSED,
    RELEASE_WAIT
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_class_e;

  // Lowest-numbered active row in a column sample.
  function automatic logic [1:0] row_index(input logic [3:0] low);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (low[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Number of active rows, saturated at 2 (anything above one is "many").
  function automatic logic [1:0] low_count(input logic [3:0] low);
    logic [2:0] n;
    n = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
    return (n > 3'd1) ? 2'd2 : n[1:0];
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column driver, row synchronizer and per-frame classifier for a 4x4 matrix keypad.
module keypad_col_scan
  import game_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  output logic             frame_done,
  output frame_class_e     frame_class,
  output logic [KEY_W-1:0] frame_code
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [3:0]       col_out_q, col_out_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [KEY_W-1:0] acc_code_q, acc_code_d;
  logic             frame_done_q, frame_done_d;
  frame_class_e     frame_class_q, frame_class_d;
  logic [KEY_W-1:0] frame_code_q, frame_code_d;

  logic [3:0]       low;
  logic [1:0]       col_cnt, base_cnt, new_cnt;
  logic [2:0]       sum_cnt;
  logic [KEY_W-1:0] base_code, new_code;

  always_comb begin
    sync1_d       = row_in;
    sync2_d       = sync1_q;
    dwell_d       = dwell_q;
    col_d         = col_q;
    col_out_d     = col_out_q;
    acc_cnt_d     = acc_cnt_q;
    acc_code_d    = acc_code_q;
    frame_done_d  = 1'b0;
    frame_class_d = frame_class_q;
    frame_code_d  = frame_code_q;

    // Column 0 starts a fresh frame accumulation.
    low       = ~sync2_q;
    col_cnt   = low_count(low);
    base_cnt  = (col_q == '0) ? 2'd0 : acc_cnt_q;
    base_code = (col_q == '0) ? '0 : acc_code_q;
    sum_cnt   = 3'(base_cnt) + 3'(col_cnt);
    new_cnt   = (sum_cnt > 3'd1) ? 2'd2 : sum_cnt[1:0];
    new_code  = (base_cnt == 2'd0 && col_cnt == 2'd1) ? {row_index(low), col_q} : base_code;

    if (dwell_q == DIV_W'(SCAN_DIV - 1)) begin
      dwell_d    = '0;
      col_d      = COL_W'(col_q + COL_W'(1));
      col_out_d  = {col_out_q[2:0], col_out_q[3]};
      acc_cnt_d  = new_cnt;
      acc_code_d = new_code;
      if (col_q == COL_W'(NUM_COLS - 1)) begin
        frame_done_d  = 1'b1;
        frame_code_d  = new_code;
        frame_class_d = (new_cnt == 2'd0) ? NONE : (new_cnt == 2'd1) ? SINGLE : MULTI;
      end
    end else begin
      dwell_d = DIV_W'(dwell_q + DIV_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 4'hF;
      sync2_q       <= 4'hF;
      dwell_q       <= '0;
      col_q         <= '0;
      col_out_q     <= 4'b1110;
      acc_cnt_q     <= 2'd0;
      acc_code_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_class_q <= NONE;
      frame_code_q  <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      dwell_q       <= dwell_d;
      col_q         <= col_d;
      col_out_q     <= col_out_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_code_q    <= acc_code_d;
      frame_done_q  <= frame_done_d;
      frame_class_q <= frame_class_d;
      frame_code_q  <= frame_code_d;
    end
  end

  assign col_out     = col_out_q;
  assign frame_done  = frame_done_q;
  assign frame_class = frame_class_q;
  assign frame_code  = frame_code_q;

endmodule

// File: rtl/keypad_scanner.sv
// Debounced 4x4 keypad scanner: one keypad_enable pulse per clean press, no auto-repeat.
module keypad_scanner
  import game_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  output logic [KEY_W-1:0] keypad_data,
  output logic             keypad_enable,
  output logic             key_held
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

  logic             frame_done;
  frame_class_e     frame_class;
  logic [KEY_W-1:0] frame_code;

  kp_state_e        state_q, state_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [KEY_W-1:0] data_q, data_d;
  logic             ken_q, ken_d;
  logic             held_q, held_d;
  logic             cnt_hit, accept;

  keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
    .clk         (clk),
    .reset       (reset),
    .row_in      (row_in),
    .col_out     (col_out),
    .frame_done  (frame_done),
    .frame_class (frame_class),
    .frame_code  (frame_code)
  );

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ken_d   = 1'b0;
    accept  = 1'b0;
    cnt_inc = CNT_W'(cnt_q + CNT_W'(1));
    cnt_hit = (cnt_inc == CNT_W'(DEBOUNCE_FRAMES));

    if (frame_done) begin
      case (state_q)
        IDLE: begin
          if (frame_class == SINGLE) begin
            cand_d = frame_code;
            cnt_d  = CNT_W'(1);
            if (DEBOUNCE_FRAMES == 1) accept = 1'b1;
            else                      state_d = CANDIDATE;
          end
        end
        CANDIDATE: begin
          if (frame_class == SINGLE && frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_hit) accept = 1'b1;
          end else if (frame_class == SINGLE) begin
            cand_d = frame_code;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          // A multi-key frame still counts as held.
          if (frame_class == NONE) begin
            cnt_d   = CNT_W'(1);
            state_d = (DEBOUNCE_FRAMES == 1) ? IDLE : RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (frame_class == NONE) begin
            cnt_d = cnt_inc;
            if (cnt_hit) state_d = IDLE;
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A press accepted while disabled is consumed without a pulse.
    if (accept) begin
      state_d = PRESSED;
      if (enable) begin
        data_d = cand_d;
        ken_d  = 1'b1;
      end
    end

    held_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ken_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ken_q   <= ken_d;
      held_q  <= held_d;
    end
  end

  assign keypad_data   = data_q;
  assign keypad_enable = ken_q;
  assign key_held      = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a modelled key matrix, pulses checked against expected code and cycle.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DF = 3;
  localparam int FR = 4 * SD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] keypad_data;
  logic       keypad_enable;
  logic       key_held;
  logic [15:0] keys = 16'h0000;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dbl = 0;
  logic prev_en = 1'b0;
  int obs_code[$];
  int obs_cyc[$];
  int exp_code[$];
  int exp_cyc[$];
  int ec, ecy, oc, ocy;

  always #5 clk = ~clk;

  // Pressed key (row r, col c) pulls row r low while column c is driven.
  always_comb begin
    row_in = 4'hF;
    for (int k = 0; k < 16; k++) begin
      if (keys[k] && !col_out[k % 4]) row_in[k / 4] = 1'b0;
    end
  end

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .row_in        (row_in),
    .col_out       (col_out),
    .keypad_data   (keypad_data),
    .keypad_enable (keypad_enable),
    .key_held      (key_held)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (keypad_enable) begin
      obs_code.push_back(int'(keypad_data));
      obs_cyc.push_back(cyc);
      if (prev_en) dbl++;
    end
    prev_en = keypad_enable;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    prev_en = 1'b0;
    obs_code.delete(); obs_cyc.delete();
    exp_code.delete(); exp_cyc.delete();
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    keys = 16'h0000;
    enable = 1'b1;
    do_reset();
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL reset col_out: got %b expected 1110", col_out); end
    total++; if (keypad_data !== 4'h0) begin bad++; $display("FAIL reset keypad_data: got %h expected 0", keypad_data); end
    total++; if (keypad_enable !== 1'b0) begin bad++; $display("FAIL reset keypad_enable: got %b expected 0", keypad_enable); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset key_held: got %b expected 0", key_held); end
    for (int i = 0; i < 10 * FR; i++) begin
      tick();
      exp_col = ~(4'(1) << ((cyc / SD) % 4));
      total++;
      if (col_out !== exp_col) begin
        bad++; $display("FAIL idle_scan col_out cycle %0d: got %b expected %b", cyc, col_out, exp_col);
      end
    end
    total++; if (obs_code.size() != 0) begin bad++; $display("FAIL idle_scan pulses: got %0d expected 0", obs_code.size()); end
    total++; if (keypad_data !== 4'h0) begin bad++; $display("FAIL idle_scan keypad_data: got %h expected 0", keypad_data); end
  endtask

  task automatic test_single_press();
    do_reset();
    keys = 16'h0200;
    exp_code.push_back(9); exp_cyc.push_back(3 * FR + 1);
    run_to(3 * FR);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL press9 held_early: got %b expected 0", key_held); end
    run_to(3 * FR + 1);
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press9 held_on_accept: got %b expected 1", key_held); end
    run_to(6 * FR);
    keys = 16'h0000;
    run_to(9 * FR);
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press9 held_before_release: got %b expected 1", key_held); end
    run_to(9 * FR + 1);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL press9 held_after_release: got %b expected 0", key_held); end
    total++; if (keypad_data !== 4'h9) begin bad++; $display("FAIL press9 data_hold: got %h expected 9", keypad_data); end
    while (exp_code.size() > 0) begin
      ec = exp_code.pop_front(); ecy = exp_cyc.pop_front(); total++;
      if (obs_code.size() == 0) begin bad++; $display("FAIL press9 pulse: got none expected code %0d at cycle %0d", ec, ecy); end
      else begin
        oc = obs_code.pop_front(); ocy = obs_cyc.pop_front();
        if (oc !== ec || ocy !== ecy) begin bad++; $display("FAIL press9 pulse: got code %0d cycle %0d expected code %0d cycle %0d", oc, ocy, ec, ecy); end
      end
    end
    total++; if (obs_code.size() != 0) begin bad++; $display("FAIL press9 extra_pulses: got %0d expected 0", obs_code.size()); end
  endtask

  task automatic test_bounce();
    do_reset();
    keys = 16'h0020;
    exp_code.push_back(5); exp_cyc.push_back(6 * FR + 1);
    run_to(2 * FR); keys = 16'h0000;
    run_to(3 * FR); keys = 16'h0020;
    run_to(7 * FR); keys = 16'h0000;
    run_to(11 * FR);
    while (exp_code.size() > 0) begin
      ec = exp_code.pop_front(); ecy = exp_cyc.pop_front(); total++;
      if (obs_code.size() == 0) begin bad++; $display("FAIL bounce pulse: got none expected code %0d at cycle %0d", ec, ecy); end
      else begin
        oc = obs_code.pop_front(); ocy = obs_cyc.pop_front();
        if (oc !== ec || ocy !== ecy) begin bad++; $display("FAIL bounce pulse: got code %0d cycle %0d expected code %0d cycle %0d", oc, ocy, ec, ecy); end
      end
    end
    total++; if (obs_code.size() != 0) begin bad++; $display("FAIL bounce extra_pulses: got %0d expected 0", obs_code.size()); end
  endtask

  task automatic test_multi();
    do_reset();
    keys = 16'h1008;
    run_to(5 * FR);
    total++; if (obs_code.size() != 0) begin bad++; $display("FAIL multi no_pulse: got %0d pulses expected 0", obs_code.size()); end
    keys = 16'h0008;
    exp_code.push_back(3); exp_cyc.push_back(8 * FR + 1);
    run_to(10 * FR);
    while (exp_code.size() > 0) begin
      ec = exp_code.pop_front(); ecy = exp_cyc.pop_front(); total++;
      if (obs_code.size() == 0) begin bad++; $display("FAIL multi pulse: got none expected code %0d at cycle %0d", ec, ecy); end
      else begin
        oc = obs_code.pop_front(); ocy = obs_cyc.pop_front();
        if (oc !== ec || ocy !== ecy) begin bad++; $display("FAIL multi pulse: got code %0d cycle %0d expected code %0d cycle %0d", oc, ocy, ec, ecy); end
      end
    end
    total++; if (obs_code.size() != 0) begin bad++; $display("FAIL multi extra_pulses: got %0d expected 0", obs_code.size()); end
  endtask

  task automatic test_enable_gate();
    do_reset();
    enable = 1'b0;
    keys = 16'h0080;
    run_to(3 * FR + 1);
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL gate held_while_disabled: got %b expected 1", key_held); end
    run_to(4 * FR); enable = 1'b1;
    run_to(5 * FR); keys = 16'h0000;
    run_to(9 * FR);
    total++; if (obs_code.size() != 0) begin bad++; $display("FAIL gate swallowed: got %0d pulses expected 0", obs_code.size()); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL gate released: got %b expected 0", key_held); end
    keys = 16'h0080;
    exp_code.push_back(7); exp_cyc.push_back(12 * FR + 1);
    run_to(14 * FR);
    keys = 16'h0000;
    while (exp_code.size() > 0) begin
      ec = exp_code.pop_front(); ecy = exp_cyc.pop_front(); total++;
      if (obs_code.size() == 0) begin bad++; $display("FAIL gate pulse: got none expected code %0d at cycle %0d", ec, ecy); end
      else begin
        oc = obs_code.pop_front(); ocy = obs_cyc.pop_front();
        if (oc !== ec || ocy !== ecy) begin bad++; $display("FAIL gate pulse: got code %0d cycle %0d expected code %0d cycle %0d", oc, ocy, ec, ecy); end
      end
    end
    total++; if (obs_code.size() != 0) begin bad++; $display("FAIL gate extra_pulses: got %0d expected 0", obs_code.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    keys = 16'h0400;
    run_to(2 * FR + 8);
    total++; if (obs_code.size() != 0) begin bad++; $display("FAIL reset_mid pre_reset: got %0d pulses expected 0", obs_code.size()); end
    do_reset();
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL reset_mid col_out: got %b expected 1110", col_out); end
    exp_code.push_back(10); exp_cyc.push_back(3 * FR + 1);
    run_to(3 * FR);
    total++; if (obs_code.size() != 0) begin bad++; $display("FAIL reset_mid early_pulse: got %0d pulses expected 0", obs_code.size()); end
    run_to(5 * FR);
    keys = 16'h0000;
    while (exp_code.size() > 0) begin
      ec = exp_code.pop_front(); ecy = exp_cyc.pop_front(); total++;
      if (obs_code.size() == 0) begin bad++; $display("FAIL reset_mid pulse: got none expected code %0d at cycle %0d", ec, ecy); end
      else begin
        oc = obs_code.pop_front(); ocy = obs_cyc.pop_front();
        if (oc !== ec || ocy !== ecy) begin bad++; $display("FAIL reset_mid pulse: got code %0d cycle %0d expected code %0d cycle %0d", oc, ocy, ec, ecy); end
      end
    end
    total++; if (obs_code.size() != 0) begin bad++; $display("FAIL reset_mid extra_pulses: got %0d expected 0", obs_code.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    keys = 16'h0001;
    exp_code.push_back(0); exp_cyc.push_back(3 * FR + 1);
    run_to(4 * FR); keys = 16'h0000;
    run_to(8 * FR);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL b2b released: got %b expected 0", key_held); end
    keys = 16'h8000;
    exp_code.push_back(15); exp_cyc.push_back(11 * FR + 1);
    run_to(12 * FR);
    keys = 16'h0040;
    run_to(17 * FR);
    total++; if (keypad_data !== 4'hF) begin bad++; $display("FAIL b2b data_hold: got %h expected f", keypad_data); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL b2b held_on_switch: got %b expected 1", key_held); end
    keys = 16'h0000;
    while (exp_code.size() > 0) begin
      ec = exp_code.pop_front(); ecy = exp_cyc.pop_front(); total++;
      if (obs_code.size() == 0) begin bad++; $display("FAIL b2b pulse: got none expected code %0d at cycle %0d", ec, ecy); end
      else begin
        oc = obs_code.pop_front(); ocy = obs_cyc.pop_front();
        if (oc !== ec || ocy !== ecy) begin bad++; $display("FAIL b2b pulse: got code %0d cycle %0d expected code %0d cycle %0d", oc, ocy, ec, ecy); end
      end
    end
    total++; if (obs_code.size() != 0) begin bad++; $display("FAIL b2b extra_pulses: got %0d expected 0", obs_code.size()); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_enable_gate();
    test_reset_mid();
    test_back_to_back();
    total++; if (dbl != 0) begin bad++; $display("FAIL consecutive_pulses: got %0d expected 0", dbl); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Upstream feeder of the game controller. Drives a 4x4 matrix keypad column by column, synchronizes and debounces the row returns, and emits one keypad_enable pulse per debounced key press with keypad_data holding the key code. Held keys never repeat. A new press is only accepted after a clean release.

Parameters:
SCAN_DIV, 4, clocks per column dwell (must be >= 4); row sampled on last dwell cycle.
DEBOUNCE_FRAMES, 3, consecutive identical full-scan frames required to accept a press or release (>= 1).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  high = presses may be reported; low = scanning continues, pulses suppressed
row_in  input  4  keypad rows, active-low (external pull-ups), asynchronous
col_out  output  4  column drive, active-low one-hot
keypad_data  output  4  code of last accepted key = {row[1:0], col[1:0]}; held until next accept
keypad_enable  output  1  one-clock pulse, keypad_data valid in same cycle
key_held  output  1  level, high while FSM is in PRESSED or RELEASE_WAIT

Behaviour:
- Clocking/reset:
  - Reset is synchronous and active-high on clk. All state is updated only on posedge clk.
  - Reset values: col_out=4'b1110 (column 0 driven), keypad_data=0, keypad_enable=0, key_held=0, FSM=IDLE, all counters=0.
  - Reset mid-scan or mid-debounce discards everything. A key still held after reset goes through the full debounce.
- Synchronizer: 2-flop on row_in. Sampled value lags the pins by 2 clocks.
- Scan:
  - dwell counter 0..SCAN_DIV-1. On dwell==SCAN_DIV-1, capture synced row bits for the current column and advance the column 0->1->2->3->0.
  - col_out changes on the clock after capture. One frame = 4*SCAN_DIV clocks.
- Frame classify, at the column-3 capture:
  - NONE: no row low in any column.
  - SINGLE(code): exactly one row/column intersection low.
  - MULTI: more than one low. MULTI is treated as NONE for press acceptance and as "not released" while in PRESSED.
- Debounce FSM, evaluated once per frame end:
  - IDLE: SINGLE(c) -> CANDIDATE, cand=c, cnt=1 (if DEBOUNCE_FRAMES==1, go straight to accept).
  - CANDIDATE:
    - SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_FRAMES -> accept.
    - SINGLE(other) -> restart with the new code, cnt=1.
    - NONE or MULTI -> IDLE.
  - Accept:
    - If enable is high: keypad_data<=cand and keypad_enable=1 for exactly one clock (the clock after frame end).
    - FSM -> PRESSED in either case. A press accepted while enable is low is swallowed; it is not replayed later.
  - PRESSED: NONE -> RELEASE_WAIT, rcnt=1. Anything else stays in PRESSED.
  - RELEASE_WAIT:
    - NONE -> rcnt+1; when rcnt reaches DEBOUNCE_FRAMES -> IDLE.
    - Any key -> PRESSED.
- Press-to-pulse latency from a clean press: at most (DEBOUNCE_FRAMES+1) frames + 3 clocks.
- enable rising while a key is held does not produce a pulse; the key must be released and pressed again.
- keypad_enable never asserts on two consecutive clocks.

Decomposition:
- Shared package game_pkg:
  - KEY_W=4
  - column count 4
  - FSM state enum {IDLE, CANDIDATE, PRESSED, RELEASE_WAIT}
  - frame class enum {NONE, SINGLE, MULTI}
- One natural sub-module: keypad_col_scan. It holds the synchronizer, dwell counter, column rotation and per-frame capture, and outputs frame_done, frame_class and frame_code.
- keypad_scanner holds the debounce FSM and the output registers.

Test Plan:
- Reset, row_in=4'hF for 10 frames -> col_out cycles 1110,1101,1011,0111 every 4 clocks; keypad_enable never high; keypad_data=0.
- Row 2 low only while col_out=1101, held 6 frames (SCAN_DIV=4, DEBOUNCE_FRAMES=3) -> exactly one keypad_enable pulse, 3 frames + 1 clock after the first valid frame, with keypad_data=4'h9; key_held=1 until 3 release frames complete.
- Bounce: key 4'h5 valid 2 frames, open 1 frame, valid 3 frames -> exactly one pulse, data=4'h5, after the second burst only.
- Keys 4'h3 and 4'hC held together for 5 frames -> no pulse. Then 4'hC released with 4'h3 still held -> pulse with data=4'h3 after 3 frames.
- enable=0, press 4'h7 for 5 frames, raise enable while held, then release -> no pulse. Press again with enable=1 -> one pulse, data=4'h7.
- Assert reset for 1 clock during CANDIDATE cnt=2 with the key still held -> no pulse for 3 full frames after reset, then one pulse; col_out=1110 on the clock after reset.
